ctrl_relogio: RTL and testbench

Central controller for the clock datapath. It derives the 1 Hz time base from the system clock and issues one-cycle increment pulses to the seconds, minutes and hours counter machines, with the carries between them. It also runs the user time-setting state machine from two buttons and drives display-blink enables for the field being adjusted. It sits between the button synchronisers and the `maq_*` counter machines.

---
 rtl/ctrl_relogio.sv | 144 ++++++++++++++
 tb/tb_ctrl_relogio.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_relogio.sv
// Clock controller: 1 Hz tick divider, seconds/minutes/hours increment pulses with carries,
// button-driven time-setting FSM (RUN -> SET_H -> SET_M -> RUN) and display blink enables.
module ctrl_relogio #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_btn_modo,
  input  logic       ctrl_btn_inc,
  input  logic [2:0] ctrl_seg_msd,
  input  logic [3:0] ctrl_seg_lsd,
  input  logic [2:0] ctrl_min_msd,
  input  logic [3:0] ctrl_min_lsd,
  output logic       ctrl_inc_seg,
  output logic       ctrl_inc_min,
  output logic       ctrl_inc_hora,
  output logic       ctrl_zera_seg,
  output logic [1:0] ctrl_modo,
  output logic       ctrl_vis_h,
  output logic       ctrl_vis_m
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } modo_t;

  modo_t         state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          flag_q, flag_d;
  logic          modo_prev_q, inc_prev_q;
  logic          inc_seg_q, inc_seg_d;
  logic          inc_min_q, inc_min_d;
  logic          inc_hora_q, inc_hora_d;
  logic          zera_q, zera_d;

  logic modo_edge, inc_edge, tick, seg_59, min_59;

  assign modo_edge = ctrl_btn_modo & ~modo_prev_q;
  assign inc_edge  = ctrl_btn_inc & ~inc_prev_q;
  assign tick      = (div_q == DIV_LAST);
  assign seg_59    = (ctrl_seg_msd == 3'd5) && (ctrl_seg_lsd == 4'd9);
  assign min_59    = (ctrl_min_msd == 3'd5) && (ctrl_min_lsd == 4'd9);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    blink_cnt_d = blink_cnt_q;
    flag_d      = flag_q;
    inc_seg_d   = 1'b0;
    inc_min_d   = 1'b0;
    inc_hora_d  = 1'b0;
    zera_d      = 1'b0;

    // A mode edge always wins; a coincident tick or increment edge is dropped.
    case (state_q)
      RUN: begin
        if (modo_edge) begin
          state_d = SET_H;
          div_d   = '0;
        end else begin
          div_d = tick ? '0 : div_q + DW'(1);
          if (tick) begin
            inc_seg_d  = 1'b1;
            inc_min_d  = seg_59;
            inc_hora_d = seg_59 & min_59;
          end
        end
      end
      SET_H: begin
        div_d = '0;
        if (modo_edge) state_d = SET_M;
        else if (inc_edge) inc_hora_d = 1'b1;
      end
      SET_M: begin
        div_d = '0;
        if (modo_edge) begin
          state_d = RUN;
          zera_d  = 1'b1;
        end else if (inc_edge) begin
          inc_min_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        div_d   = '0;
      end
    endcase

    // Blink phase is parked at (0, visible) whenever RUN is involved, so each adjust session starts visible.
    if (state_q == RUN || state_d == RUN) begin
      blink_cnt_d = '0;
      flag_d      = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      flag_d      = ~flag_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge ctrl_clock) begin
    if (ctrl_reset) begin
      state_q     <= RUN;
      div_q       <= '0;
      blink_cnt_q <= '0;
      flag_q      <= 1'b1;
      modo_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      inc_seg_q   <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_hora_q  <= 1'b0;
      zera_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      blink_cnt_q <= blink_cnt_d;
      flag_q      <= flag_d;
      modo_prev_q <= ctrl_btn_modo;
      inc_prev_q  <= ctrl_btn_inc;
      inc_seg_q   <= inc_seg_d;
      inc_min_q   <= inc_min_d;
      inc_hora_q  <= inc_hora_d;
      zera_q      <= zera_d;
    end
  end

  assign ctrl_inc_seg  = inc_seg_q;
  assign ctrl_inc_min  = inc_min_q;
  assign ctrl_inc_hora = inc_hora_q;
  assign ctrl_zera_seg = zera_q;
  assign ctrl_modo     = state_q;
  assign ctrl_vis_h    = (state_q != SET_H) | flag_q;
  assign ctrl_vis_m    = (state_q != SET_M) | flag_q;

endmodule

// File: tb/tb_ctrl_relogio.sv
// Bench for ctrl_relogio: cycle-level reference model compared every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_ctrl_relogio;

  localparam int TICK  = 4;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_modo, btn_inc;
  logic [2:0] seg_msd, min_msd;
  logic [3:0] seg_lsd, min_lsd;
  logic       inc_seg, inc_min, inc_hora, zera_seg, vis_h, vis_m;
  logic [1:0] modo;

  ctrl_relogio #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
    .ctrl_clock   (clk),
    .ctrl_reset   (rst),
    .ctrl_btn_modo(btn_modo),
    .ctrl_btn_inc (btn_inc),
    .ctrl_seg_msd (seg_msd),
    .ctrl_seg_lsd (seg_lsd),
    .ctrl_min_msd (min_msd),
    .ctrl_min_lsd (min_lsd),
    .ctrl_inc_seg (inc_seg),
    .ctrl_inc_min (inc_min),
    .ctrl_inc_hora(inc_hora),
    .ctrl_zera_seg(zera_seg),
    .ctrl_modo    (modo),
    .ctrl_vis_h   (vis_h),
    .ctrl_vis_m   (vis_m)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode as integer, RUN-cycle count since last restart,
  // and elapsed cycles since leaving RUN for the blink phase.
  int   m_mode = 0;
  int   m_t = 0;
  int   m_n = 0;
  bit   m_pm = 0, m_pi = 0;
  bit   m_seg = 0, m_min = 0, m_hora = 0, m_zera = 0;
  bit   model_ok = 0;

  always @(posedge clk) begin
    bit me, ie, s59, mn59;
    m_seg = 0; m_min = 0; m_hora = 0; m_zera = 0;
    if (rst) begin
      m_mode = 0; m_t = 0; m_n = 0; m_pm = 0; m_pi = 0;
    end else begin
      me   = btn_modo && !m_pm;
      ie   = btn_inc && !m_pi;
      s59  = (seg_msd == 5) && (seg_lsd == 9);
      mn59 = (min_msd == 5) && (min_lsd == 9);
      case (m_mode)
        0: if (me) begin
             m_mode = 1; m_n = 0;
           end else begin
             m_t++;
             if (m_t % TICK == 0) begin
               m_seg = 1; m_min = s59; m_hora = s59 && mn59;
             end
           end
        1: begin
             m_n++;
             if (me) m_mode = 2;
             else if (ie) m_hora = 1;
           end
        default: if (me) begin
             m_mode = 0; m_t = 0; m_zera = 1;
           end else begin
             m_n++;
             if (ie) m_min = 1;
           end
      endcase
      m_pm = btn_modo;
      m_pi = btn_inc;
    end
    model_ok = 1;
  end

  // compare process plus pulse counters
  int cnt_seg = 0, cnt_min = 0, cnt_hora = 0;
  always @(negedge clk) begin
    bit flag;
    if (model_ok) begin
      flag = ((m_n / BLINK) % 2) == 0;
      chk("cmp_inc_seg", inc_seg, m_seg);
      chk("cmp_inc_min", inc_min, m_min);
      chk("cmp_inc_hora", inc_hora, m_hora);
      chk("cmp_zera_seg", zera_seg, m_zera);
      chk("cmp_modo", modo, 32'(m_mode));
      chk("cmp_vis_h", vis_h, (m_mode != 1) || flag);
      chk("cmp_vis_m", vis_m, (m_mode != 2) || flag);
      cnt_seg  += int'(inc_seg === 1'b1);
      cnt_min  += int'(inc_min === 1'b1);
      cnt_hora += int'(inc_hora === 1'b1);
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      btn_inc = 1; cyc(2);
      btn_inc = 0; cyc(2);
    end
  endtask

  int b_seg, b_min, b_hora;
  task automatic snap();
    b_seg = cnt_seg; b_min = cnt_min; b_hora = cnt_hora;
  endtask

  logic v[8];
  logic e;

  initial begin
    rst = 1; btn_modo = 0; btn_inc = 0;
    seg_msd = 5; seg_lsd = 8; min_msd = 5; min_lsd = 9;
    cyc(2);
    chk("reset_modo", modo, 0);
    chk("reset_inc_seg", inc_seg, 0);
    chk("reset_vis_h", vis_h, 1);
    chk("reset_vis_m", vis_m, 1);

    // tick and carries
    rst = 0;
    cyc(3);
    chk("tick_early", inc_seg, 0);
    cyc(1);
    chk("first_tick_seg", inc_seg, 1);
    chk("first_tick_min", inc_min, 0);
    chk("first_tick_hora", inc_hora, 0);
    seg_lsd = 9;
    cyc(4);
    chk("carry_seg", inc_seg, 1);
    chk("carry_min", inc_min, 1);
    chk("carry_hora", inc_hora, 1);
    cyc(1);
    chk("carry_one_cycle", inc_seg, 0);
    seg_lsd = 8;

    // RUN -> SET_H, then set hours
    btn_modo = 1; cyc(1);
    chk("mode_to_set_h", modo, 1);
    cyc(4); btn_modo = 0; cyc(2);
    snap();
    press_inc(3);
    cyc(8);
    chk("set_h_hora_count", cnt_hora - b_hora, 3);
    chk("set_h_seg_count", cnt_seg - b_seg, 0);
    chk("set_h_min_count", cnt_min - b_min, 0);

    // SET_M, set minutes with minutes=59
    btn_modo = 1; cyc(1);
    chk("mode_to_set_m", modo, 2);
    cyc(4); btn_modo = 0; cyc(2);
    snap();
    press_inc(2);
    cyc(6);
    chk("set_m_min_count", cnt_min - b_min, 2);
    chk("set_m_hora_count", cnt_hora - b_hora, 0);
    chk("set_m_seg_count", cnt_seg - b_seg, 0);

    // SET_M -> RUN
    btn_modo = 1; cyc(1);
    chk("mode_to_run", modo, 0);
    chk("zera_pulse", zera_seg, 1);
    cyc(1);
    chk("zera_one_cycle", zera_seg, 0);
    cyc(2);
    chk("restart_tick_early", inc_seg, 0);
    cyc(1);
    chk("restart_tick", inc_seg, 1);
    btn_modo = 0; seg_lsd = 0;
    cyc(1);

    // both buttons rise together in SET_H
    btn_modo = 1; cyc(1);
    chk("sim_enter_set_h", modo, 1);
    btn_modo = 0; cyc(2);
    snap();
    btn_modo = 1; btn_inc = 1; cyc(1);
    chk("sim_modo", modo, 2);
    cyc(2);
    btn_modo = 0; btn_inc = 0;
    chk("sim_no_hora", cnt_hora - b_hora, 0);
    chk("sim_no_min", cnt_min - b_min, 0);
    chk("sim_vis_h", vis_h, 1);
    for (int i = 0; i < 8; i++) begin
      v[i] = vis_m;
      cyc(1);
    end
    for (int i = 0; i < 6; i++) begin
      e = ~v[i];
      chk("vis_m_toggle", v[i+2], e);
    end

    // reset mid-adjust with increment held
    btn_inc = 1; rst = 1; cyc(1);
    chk("rst_mid_modo", modo, 0);
    chk("rst_mid_inc_min", inc_min, 0);
    chk("rst_mid_inc_hora", inc_hora, 0);
    chk("rst_mid_zera", zera_seg, 0);
    chk("rst_mid_vis_h", vis_h, 1);
    chk("rst_mid_vis_m", vis_m, 1);
    rst = 0;
    snap();
    cyc(10);
    chk("rst_held_no_min", cnt_min - b_min, 0);
    chk("rst_held_no_hora", cnt_hora - b_hora, 0);
    btn_inc = 0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
